// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: cache line type, FSM state encoding,
// and the side encoding used to remember which port was granted last.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef logic [ARB_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERV_I,
        ARB_SERV_D
    } arb_state_t;

    typedef enum logic {
        ARB_SIDE_I,
        ARB_SIDE_D
    } lc3b_arb_side;

    // Round-robin helper: the side that should win a conflict.
    function automatic lc3b_arb_side arb_opposite(input lc3b_arb_side s);
        return (s == ARB_SIDE_I) ? ARB_SIDE_D : ARB_SIDE_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_perf.sv
// Free-running 32-bit event counters for the memory arbiter: grants per
// side and IDLE cycles in which both sides were requesting. Counters wrap.
module mem_arbiter_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_grant,
    input  logic        d_grant,
    input  logic        conflict,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
);

    // Count one event per cycle on each strobe; cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (i_grant)  perf_i_grants  <= perf_i_grants + 32'd1;
            if (d_grant)  perf_d_grants  <= perf_d_grants + 32'd1;
            if (conflict) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss ports for the single pmem port.
// One request is serviced at a time; conflicts are resolved round-robin.
// Handshake: a requester raises its level request and holds it (with stable
// address/data) until its one-cycle resp pulse; pmem strobes are held until
// pmem_resp, which is forwarded to the granted side in the same cycle.
// Optional feature: define MEM_ARB_PERF_EN to build the grant/conflict
// counters; otherwise the perf outputs are tied to 0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts,
    output arb_state_t        dbg_state
);

    arb_state_t   state;
    lc3b_arb_side last_grant;
    logic         d_req;
    logic         start_i;
    logic         start_d;

    assign d_req     = d_read | d_write;
    assign dbg_state = state;

    // IDLE arbitration: a lone requester wins; on conflict the side opposite
    // the previous grant wins.
    assign start_d = (state == ARB_IDLE) & d_req &
                     (~i_read | (arb_opposite(last_grant) == ARB_SIDE_D));
    assign start_i = (state == ARB_IDLE) & i_read &
                     ~(d_req & (arb_opposite(last_grant) == ARB_SIDE_D));

    // State register: grant from IDLE, return to IDLE on pmem_resp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_SIDE_I;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (start_d) begin
                        state      <= ARB_SERV_D;
                        last_grant <= ARB_SIDE_D;
                    end else if (start_i) begin
                        state      <= ARB_SERV_I;
                        last_grant <= ARB_SIDE_I;
                    end
                end
                ARB_SERV_I,
                ARB_SERV_D: begin
                    if (pmem_resp) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Output decode from state; the ungranted side sees zero data and no resp.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_rdata      = '0;
        i_resp       = 1'b0;
        d_rdata      = '0;
        d_resp       = 1'b0;
        case (state)
            ARB_SERV_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_addr;
                i_rdata      = pmem_rdata;
                i_resp       = pmem_resp;
            end
            ARB_SERV_D: begin
                // Write takes priority if both D strobes are (illegally) high.
                pmem_write   = d_write;
                pmem_read    = ~d_write;
                pmem_address = d_addr;
                pmem_wdata   = d_wdata;
                d_rdata      = pmem_rdata;
                d_resp       = pmem_resp;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = (state == ARB_IDLE) & i_read & d_req;

    mem_arbiter_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .i_grant        (start_i),
        .d_grant        (start_d),
        .conflict       (conflict),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// requesters and a random memory, all checked cycle by cycle against a
// transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [31:0]   perf_i_grants;
  logic [31:0]   perf_d_grants;
  logic [31:0]   perf_conflicts;
  arb_state_t    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who (if anyone) owns the memory port, who won last.
  // owner: 0 = nobody, 1 = I-side, 2 = D-side.  prev_d: last grant went to D.
  int          owner;
  bit          prev_d;
  int unsigned m_ig, m_dg, m_conf;
  bit          exp_i_done, exp_d_done;

  // Observed traffic
  int          obs_i_resp, obs_d_resp, obs_pr, obs_pw;
  bit          prev_strobe;
  logic [0:0]  exp_q[$];
  logic [0:0]  obs_q[$];

  task automatic model_reset();
    owner  = 0;
    prev_d = 1'b0;
    m_ig = 0; m_dg = 0; m_conf = 0;
  endtask

  // One clock cycle: inputs are already driven; compare, advance model, tick.
  task automatic step();
    logic          want_i, want_d;
    logic          e_pr, e_pw, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd, e_ird, e_drd;
    #1;
    want_i = i_read;
    want_d = d_read | d_write;
    e_pr   = (owner == 1) || (owner == 2 && !d_write);
    e_pw   = (owner == 2) && d_write;
    e_addr = (owner == 1) ? i_addr : (owner == 2) ? d_addr : '0;
    e_wd   = (owner == 2) ? d_wdata : '0;
    e_ird  = (owner == 1) ? pmem_rdata : '0;
    e_drd  = (owner == 2) ? pmem_rdata : '0;
    e_ir   = (owner == 1) && pmem_resp;
    e_dr   = (owner == 2) && pmem_resp;
    check("pmem_read", pmem_read, e_pr);
    check("pmem_write", pmem_write, e_pw);
    check("pmem_address", pmem_address, e_addr);
    check("pmem_wdata", pmem_wdata, e_wd);
    check("i_rdata", i_rdata, e_ird);
    check("d_rdata", d_rdata, e_drd);
    check("i_resp", i_resp, e_ir);
    check("d_resp", d_resp, e_dr);
`ifdef MEM_ARB_PERF_EN
    check("perf_i_grants", perf_i_grants, m_ig);
    check("perf_d_grants", perf_d_grants, m_dg);
    check("perf_conflicts", perf_conflicts, m_conf);
`else
    check("perf_i_grants", perf_i_grants, 0);
    check("perf_d_grants", perf_d_grants, 0);
    check("perf_conflicts", perf_conflicts, 0);
`endif
    exp_i_done = e_ir;
    exp_d_done = e_dr;
    if (i_resp) obs_i_resp++;
    if (d_resp) obs_d_resp++;
    if (pmem_read) obs_pr++;
    if (pmem_write) obs_pw++;
    if ((pmem_read || pmem_write) && !prev_strobe)
      obs_q.push_back(pmem_address == d_addr);
    prev_strobe = pmem_read || pmem_write;
    // next model state
    if (reset) begin
      model_reset();
    end else if (owner == 0) begin
      if (want_i && want_d) m_conf++;
      if (want_i && want_d) owner = prev_d ? 1 : 2;
      else if (want_i)      owner = 1;
      else if (want_d)      owner = 2;
      if (owner == 1) begin m_ig++; prev_d = 1'b0; end
      if (owner == 2) begin m_dg++; prev_d = 1'b1; end
    end else if (pmem_resp) begin
      owner = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
  endtask

  task automatic clear_obs();
    obs_i_resp = 0; obs_d_resp = 0; obs_pr = 0; obs_pw = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  bit            i_pend, d_pend;
  logic [LW-1:0] a5_line;
  logic [LW-1:0] cap_line;

  initial begin
    reset = 1; idle_inputs();
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    prev_strobe = 0;
    exp_i_done = 0; exp_d_done = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    clear_obs();
    step();                              // reset-state outputs
    reset = 0;

    // I only, memory answers on the third service cycle
    a5_line = {16{8'hA5}};
    cap_line = '0;
    i_read = 1; i_addr = 16'h0040; pmem_rdata = a5_line;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      pmem_resp = (k == 3);
      if (k == 3) begin #1; cap_line = i_rdata; #0; end
      step();
    end
    i_read = 0; pmem_resp = 0;
    step();
    check("s1 i_resp count", obs_i_resp, 1);
    check("s1 d_resp count", obs_d_resp, 0);
    check("s1 pmem_read cycles", obs_pr, 3);
    check("s1 i_rdata", cap_line, a5_line);

    // D write
    d_write = 1; d_addr = 16'h1230; d_wdata = 128'h1;
    clear_obs();
    for (int k = 0; k < 3; k++) begin
      pmem_resp = (k == 2);
      step();
    end
    d_write = 0; pmem_resp = 0;
    step();
    check("s2 d_resp count", obs_d_resp, 1);
    check("s2 pmem_write cycles", obs_pw, 2);
    check("s2 pmem_read cycles", obs_pr, 0);

    // Conflict fairness from reset: D, I, D, I
    do_reset();
    i_read = 1; d_read = 1; i_addr = 16'h0100; d_addr = 16'h0200;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    prev_strobe = 0;
    for (int k = 0; k < 16; k++) begin
      pmem_resp = (k % 4 == 3);
      step();
    end
    check("s3 grant count", obs_q.size(), 4);
    for (int g = 0; g < 4; g++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("s3 grant %0d side", g), obs_q.pop_front(), exp_q.pop_front());
    end
`ifdef MEM_ARB_PERF_EN
    check("s3 perf_i", perf_i_grants, 2);
    check("s3 perf_d", perf_d_grants, 2);
    check("s3 perf_conf", perf_conflicts, 4);
    // wrap: preload I counter and grant once more
    i_read = 0; d_read = 0; pmem_resp = 0;
    dut.u_perf.perf_i_grants = 32'hFFFF_FFFF;
    m_ig = 32'hFFFF_FFFF;
    i_read = 1;
    step();
    check("wrap perf_i", perf_i_grants, 0);
    pmem_resp = 1;
    step();
    i_read = 0; pmem_resp = 0;
    step();
`else
    i_read = 0; d_read = 0; pmem_resp = 0;
    step();
`endif

    // Illegal dual D strobe: write wins
    d_read = 1; d_write = 1; d_addr = 16'h0ABC; d_wdata = 128'hDEAD_BEEF;
    clear_obs();
    for (int k = 0; k < 3; k++) begin
      pmem_resp = (k == 2);
      step();
    end
    d_read = 0; d_write = 0; pmem_resp = 0;
    step();
    check("s4 pmem_read cycles", obs_pr, 0);
    check("s4 pmem_write cycles", obs_pw, 2);

    // Reset mid-service, then stray pmem_resp in IDLE
    i_read = 1; i_addr = 16'h0777;
    clear_obs();
    step();
    step();                              // now serving I
    reset = 1;
    step();
    reset = 0; i_read = 0; pmem_resp = 1;
    step();
    step();
    pmem_resp = 0;
    step();
    check("s5 i_resp count", obs_i_resp, 0);
    check("s5 d_resp count", obs_d_resp, 0);

    // Random requesters and memory
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && $urandom_range(3) == 0) begin
        i_pend = 1; i_addr = AW'($urandom);
      end
      if (!d_pend && $urandom_range(3) == 0) begin
        int op;
        op = $urandom_range(9);
        d_pend = 1; d_addr = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_write = (op <= 4);
        d_read  = (op == 0) || (op >= 5);
      end
      i_read = i_pend;
      if (!d_pend) begin d_read = 0; d_write = 0; end
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp  = (owner != 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      reset      = ($urandom_range(299) == 0);
      step();
      if (exp_i_done) i_pend = 0;
      if (exp_d_done) d_pend = 0;
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
